bus_ready_controller: RTL

- Generates the processor READY and the DMA-controller ready for the XT bus.
- Sits directly upstream of the bus arbiter: consumes the arbiter's command strobes, address_enable_n and dma_wait_n; drives the arbiter's dma_ready input and the CPU clock-generator ready.
- Inserts programmable wait states per cycle type.
- Honours the external I/O-channel-ready line through a synchronizer.

---
 rtl/bus_ready_controller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bus_ready_controller.sv
// XT bus ready generator: per-cycle wait states plus synchronised I/O channel ready.
// Optional channel-ready timeout is compiled in with BUS_READY_TIMEOUT_EN.
module bus_ready_controller #(
   parameter int unsigned IO_WAIT_STATES  = 1,
   parameter int unsigned MEM_WAIT_STATES = 0,
   parameter int unsigned DMA_WAIT_STATES = 1,
   parameter int unsigned TIMEOUT_CYCLES  = 1023
) (
   input  logic clock,
   input  logic reset,
   input  logic io_channel_ready,
   input  logic address_enable_n,
   input  logic dma_wait_n,
   input  logic io_read_n,
   input  logic io_write_n,
   input  logic memory_read_n,
   input  logic memory_write_n,
   output logic processor_ready,
   output logic dma_ready,
   output logic bus_timeout
);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] WAIT_CNT     = 2'd1;
   localparam logic [1:0] WAIT_CHRDY   = 2'd2;
   localparam logic [1:0] HOLD_RELEASE = 2'd3;

   localparam logic [3:0] IO_N  = 4'(IO_WAIT_STATES);
   localparam logic [3:0] MEM_N = 4'(MEM_WAIT_STATES);
   localparam logic [3:0] DMA_N = 4'(DMA_WAIT_STATES);

   logic       chrdy_m;
   logic       chrdy_s;
   logic       cmd;
   logic       io_cmd;
   logic       cmd_q;
   logic       start;
   logic [1:0] state;
   logic [1:0] state_n;
   logic [3:0] count;
   logic [3:0] count_n;
   logic       path;
   logic       path_n;
   logic [3:0] load_val;
   logic       ready_n;
   logic       tmo_hit;

   assign cmd    = ~io_read_n | ~io_write_n | ~memory_read_n | ~memory_write_n;
   assign io_cmd = ~io_read_n | ~io_write_n;
   assign start  = cmd & ~cmd_q;

   // Two-flop synchroniser for the asynchronous channel-ready line
   always_ff @(posedge clock) begin
      if (reset) begin
         chrdy_m <= 1'b1;
         chrdy_s <= 1'b1;
      end else begin
         chrdy_m <= io_channel_ready;
         chrdy_s <= chrdy_m;
      end
   end

   // Command edge detector
   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_q <= 1'b0;
      end else begin
         cmd_q <= cmd;
      end
   end

   // Wait-state count to load for the cycle type being started
   always_comb begin
      load_val = MEM_N;
      unique case (1'b1)
         address_enable_n:
            load_val = DMA_N;
         (~address_enable_n & io_cmd):
            load_val = IO_N;
         (~address_enable_n & ~io_cmd):
            load_val = MEM_N;
         default:
            load_val = MEM_N;
      endcase
   end

   // Next-state, counter and path selection; a dropped command always aborts
   always_comb begin
      state_n = state;
      count_n = count;
      path_n  = path;
      unique case (state)
         IDLE: begin
            if (start) begin
               path_n  = address_enable_n;
               count_n = load_val;
               if (load_val != 4'd0) begin
                  state_n = WAIT_CNT;
               end else begin
                  state_n = WAIT_CHRDY;
               end
            end
         end
         WAIT_CNT: begin
            count_n = count - 4'd1;
            if (count <= 4'd1) begin
               count_n = 4'd0;
               state_n = WAIT_CHRDY;
            end
         end
         WAIT_CHRDY: begin
            if (chrdy_s) begin
               state_n = HOLD_RELEASE;
            end else if (tmo_hit) begin
               state_n = HOLD_RELEASE;
            end
         end
         HOLD_RELEASE: begin
            state_n = HOLD_RELEASE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      if (!cmd) begin
         state_n = IDLE;
         count_n = 4'd0;
      end
   end

   // Ready of the active path as it will be after this edge
   always_comb begin
      ready_n = 1'b1;
      if (state_n == WAIT_CNT) begin
         ready_n = 1'b0;
      end else if ((state_n == WAIT_CHRDY) && !chrdy_s) begin
         ready_n = 1'b0;
      end
   end

   // FSM state, wait counter and latched bus owner
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         count <= 4'd0;
         path  <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         path  <= path_n;
      end
   end

   // Registered ready outputs routed to the owner of the current cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         processor_ready <= 1'b1;
         dma_ready       <= 1'b1;
      end else begin
         processor_ready <= (path_n | ready_n) & dma_wait_n;
         dma_ready       <= ~path_n | ready_n;
      end
   end

`ifdef BUS_READY_TIMEOUT_EN
   localparam logic [15:0] TMO_N = 16'(TIMEOUT_CYCLES);

   logic [15:0] tcnt;
   logic [15:0] tcnt_inc;

   assign tcnt_inc = tcnt + 16'd1;
   assign tmo_hit  = (state == WAIT_CHRDY) & ~chrdy_s & (tcnt_inc == TMO_N);

   // Channel-ready watchdog: restarts on WAIT_CHRDY entry, pulses on expiry
   always_ff @(posedge clock) begin
      if (reset) begin
         tcnt        <= 16'd0;
         bus_timeout <= 1'b0;
      end else begin
         bus_timeout <= tmo_hit & cmd;
         if ((state_n == WAIT_CHRDY) && (state != WAIT_CHRDY)) begin
            tcnt <= 16'd0;
         end else if (state == WAIT_CHRDY) begin
            tcnt <= tcnt_inc;
         end
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = |TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
   assign bus_timeout    = 1'b0;
`endif

endmodule
